// File: rtl/modstick_pkg.sv
// modstick_pkg: shared definitions for the modstick register bank.
//   - register address constants for the 16-bit register bus
//   - ID register value ("MS")
//   - bus handshake FSM state encoding
package modstick_pkg;

    localparam logic [15:0] ADDR_ID        = 16'h0000;
    localparam logic [15:0] ADDR_LEDS      = 16'h0001;
    localparam logic [15:0] ADDR_DUTY      = 16'h0002;
    localparam logic [15:0] ADDR_FERR      = 16'h0003;
    localparam logic [15:0] ADDR_REQS      = 16'h0004;
    localparam logic [15:0] ADDR_UPTIME_LO = 16'h0005;
    localparam logic [15:0] ADDR_UPTIME_HI = 16'h0006;
    localparam logic [15:0] ADDR_SCRATCH   = 16'h0010;

    localparam logic [15:0] ID_VALUE       = 16'h4D53;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } bus_state_e;

endpackage

// File: rtl/modstick_pwm.sv
// modstick_pwm: 8-bit free-running PWM generator.
// The active duty is reloaded only when the counter wraps 255->0, so a duty
// change never produces a runt pulse in the middle of a period.
// Ports:
//   clk   in  1 : system clock
//   reset in  1 : synchronous reset, active low
//   duty  in  8 : requested duty (high cycles per 256)
//   out   out 1 : registered PWM output, high while cnt < active duty
module modstick_pwm (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] duty,
    output logic       out
);

    logic [7:0] cnt_r;
    logic [7:0] duty_act_r;
    logic       out_r;
    logic [7:0] cnt_nxt_s;
    logic [7:0] duty_nxt_s;

    // Next counter value and the duty that will be active alongside it.
    always_comb begin
        cnt_nxt_s  = cnt_r + 8'd1;
        duty_nxt_s = duty_act_r;
        if (cnt_r == 8'hFF) begin
            duty_nxt_s = duty;
        end else begin
            duty_nxt_s = duty_act_r;
        end
    end

    // Counter, active duty and output register; out_r tracks (cnt_r < duty_act_r).
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r      <= 8'd0;
            duty_act_r <= 8'd0;
            out_r      <= 1'b0;
        end else begin
            cnt_r      <= cnt_nxt_s;
            duty_act_r <= duty_nxt_s;
            out_r      <= (cnt_nxt_s < duty_nxt_s);
        end
    end

    assign out = out_r;

endmodule

// File: rtl/modstick_regs.sv
// modstick_regs: register-bank slave behind the Modbus RTU framer.
// Decodes single-register reads/writes into ID, LED control, PWM duty,
// frame-error and request counters, a 32-bit ms uptime counter (with a
// high-half shadow latched on low-half reads) and NScratch scratch registers.
// Optional feature macro: MODSTICK_REGS_WDOG_EN (ms watchdog that clears
// LEDS and DUTY when no write arrives within WdogMs).
// Ports:
//   clk       in  1  : system clock
//   reset     in  1  : synchronous reset, active low
//   valid     in  1  : request pending, held until ack
//   iswrite   in  1  : 1 = write, 0 = read
//   addr      in  16 : register address
//   wdata     in  16 : write data
//   rdata     out 16 : read data, valid with ack, held until next ack
//   ack       out 1  : one-cycle completion pulse
//   frame_err in  1  : one-cycle pulse per bad frame
//   leds      out 5  : LED register
//   sig1      out 1  : PWM output
//   sig2      out 1  : heartbeat (uptime bit 9)
module modstick_regs
    import modstick_pkg::*;
#(
    parameter int ClkHz    = 12000000,
    parameter int NScratch = 4,
    parameter int WdogMs   = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic        iswrite,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    input  logic        frame_err,
    output logic [4:0]  leds,
    output logic        sig1,
    output logic        sig2
);

    localparam int PreDiv = ((ClkHz / 1000) < 1) ? 1 : (ClkHz / 1000);
    localparam int PreW   = (PreDiv > 1) ? $clog2(PreDiv) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(PreDiv - 1);
    localparam int SIdxW  = (NScratch > 1) ? $clog2(NScratch) : 1;

    if ((NScratch < 1) || (NScratch > 16) || (WdogMs < 1)) begin : g_param_check
        $error("modstick_regs: NScratch must be 1..16 and WdogMs >= 1");
    end

    bus_state_e        state_r;
    bus_state_e        state_nxt_s;
    logic              access_s;
    logic              wr_s;
    logic              rd_s;

    logic [PreW-1:0]   pre_r;
    logic              tick_s;
    logic [31:0]       uptime_r;
    logic [15:0]       shadow_r;
    logic [15:0]       reqs_r;
    logic [15:0]       ferr_r;
    logic [4:0]        leds_r;
    logic [7:0]        duty_r;
    logic [15:0]       scratch_r [NScratch];

    logic [15:0]       scr_off_s;
    logic [SIdxW-1:0]  scr_idx_s;
    logic              scr_hit_s;
    logic [15:0]       rd_mux_s;
    logic [15:0]       rdata_r;
    logic              ack_r;
    logic              wdog_fire_s;

    // Bus handshake: one access per valid, then wait for the master to drop it.
    always_comb begin
        state_nxt_s = state_r;
        access_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (valid) begin
                    access_s    = 1'b1;
                    state_nxt_s = ST_ACK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACK: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (!valid) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign wr_s = access_s & iswrite;
    assign rd_s = access_s & ~iswrite;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Scratch window decode.
    always_comb begin
        scr_off_s = addr - ADDR_SCRATCH;
        scr_idx_s = scr_off_s[SIdxW-1:0];
        scr_hit_s = (addr >= ADDR_SCRATCH) && (scr_off_s < 16'(NScratch));
    end

    // Read mux over the current (pre-edge) register values.
    always_comb begin
        rd_mux_s = 16'h0000;
        case (addr)
            ADDR_ID:        rd_mux_s = ID_VALUE;
            ADDR_LEDS:      rd_mux_s = {11'h000, leds_r};
            ADDR_DUTY:      rd_mux_s = {8'h00, duty_r};
            ADDR_FERR:      rd_mux_s = ferr_r;
            ADDR_REQS:      rd_mux_s = reqs_r;
            ADDR_UPTIME_LO: rd_mux_s = uptime_r[15:0];
            ADDR_UPTIME_HI: rd_mux_s = shadow_r;
            default: begin
                if (scr_hit_s) begin
                    rd_mux_s = scratch_r[scr_idx_s];
                end else begin
                    rd_mux_s = 16'h0000;
                end
            end
        endcase
    end

    // Registered bus response: ack pulse and read data held until next access.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ack_r   <= 1'b0;
            rdata_r <= 16'h0000;
        end else begin
            ack_r <= access_s;
            if (access_s) begin
                rdata_r <= rd_mux_s;
            end
        end
    end

    // Millisecond prescaler.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pre_r <= '0;
        end else if (tick_s) begin
            pre_r <= '0;
        end else begin
            pre_r <= pre_r + PreW'(1);
        end
    end

    assign tick_s = (pre_r == PreMax);

    // Uptime counter and the high-half shadow captured on low-half reads.
    always_ff @(posedge clk) begin
        if (!reset) begin
            uptime_r <= 32'd0;
            shadow_r <= 16'h0000;
        end else begin
            if (tick_s) begin
                uptime_r <= uptime_r + 32'd1;
            end
            if (rd_s && (addr == ADDR_UPTIME_LO)) begin
                shadow_r <= uptime_r[31:16];
            end
        end
    end

    // Request and frame-error counters; a clear racing a frame error leaves 1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            reqs_r <= 16'h0000;
            ferr_r <= 16'h0000;
        end else begin
            if (access_s) begin
                reqs_r <= reqs_r + 16'd1;
            end
            if (wr_s && (addr == ADDR_FERR)) begin
                ferr_r <= {15'd0, frame_err};
            end else if (frame_err && (ferr_r != 16'hFFFF)) begin
                ferr_r <= ferr_r + 16'd1;
            end
        end
    end

`ifdef MODSTICK_REGS_WDOG_EN
    logic [31:0] wdog_r;
    logic        wdog_restart_s;

    assign wdog_restart_s = wr_s | (rd_s && (addr == ADDR_REQS));
    // Fires once on the tick that reaches WdogMs; the counter then parks there.
    assign wdog_fire_s    = tick_s && !wdog_restart_s && (wdog_r == 32'(WdogMs - 1));

    // Watchdog ms counter, saturating at WdogMs until the next restart.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wdog_r <= 32'd0;
        end else if (wdog_restart_s) begin
            wdog_r <= 32'd0;
        end else if (tick_s && (wdog_r < 32'(WdogMs))) begin
            wdog_r <= wdog_r + 32'd1;
        end
    end
`else
    assign wdog_fire_s = 1'b0;
`endif

    // Writable control registers: LEDS and DUTY.
    always_ff @(posedge clk) begin
        if (!reset) begin
            leds_r <= 5'd0;
            duty_r <= 8'd0;
        end else begin
            if (wr_s && (addr == ADDR_LEDS)) begin
                leds_r <= wdata[4:0];
            end else if (wdog_fire_s) begin
                leds_r <= 5'd0;
            end
            if (wr_s && (addr == ADDR_DUTY)) begin
                duty_r <= wdata[7:0];
            end else if (wdog_fire_s) begin
                duty_r <= 8'd0;
            end
        end
    end

    // Scratch registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NScratch; i++) begin
                scratch_r[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < NScratch; i++) begin
                if (wr_s && scr_hit_s && (scr_idx_s == SIdxW'(i))) begin
                    scratch_r[i] <= wdata;
                end
            end
        end
    end

    modstick_pwm u_pwm (
        .clk   (clk),
        .reset (reset),
        .duty  (duty_r),
        .out   (sig1)
    );

    assign rdata = rdata_r;
    assign ack   = ack_r;
    assign leds  = leds_r;
    assign sig2  = uptime_r[9];

endmodule

// File: tb/tb_modstick_regs.sv
// tb_modstick_regs: directed self-checking bench for modstick_regs.
// ClkHz=1000 makes one ms tick per clock, so uptime and the PWM counter
// both equal the number of clock edges since reset release (edge_cnt).
module tb_modstick_regs;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid = 1'b0;
    logic        iswrite = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] wdata = 16'h0000;
    logic        frame_err = 1'b0;
    logic [15:0] rdata;
    logic        ack;
    logic [4:0]  leds;
    logic        sig1;
    logic        sig2;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_cnt = 0;

    modstick_regs #(
        .ClkHz    (1000),
        .NScratch (4),
        .WdogMs   (1000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .iswrite   (iswrite),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ack       (ack),
        .frame_err (frame_err),
        .leds      (leds),
        .sig1      (sig1),
        .sig2      (sig2)
    );

    always #5 clk = ~clk;

    // Edges seen with reset released: equals uptime and PWM phase.
    always @(posedge clk) begin
        if (reset) edge_cnt <= edge_cnt + 1;
        else       edge_cnt <= 0;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One bus transaction, entered and left at a negedge (three clock edges).
    task automatic bus(input logic wr, input logic [15:0] a, input logic [15:0] d,
                       input logic fe, output logic [15:0] rd);
        valid = 1'b1; iswrite = wr; addr = a; wdata = d; frame_err = fe;
        @(posedge clk); @(negedge clk);
        frame_err = 1'b0;
        check_eq("ack_high", {31'd0, ack}, 32'd1);
        rd = rdata;
        valid = 1'b0; iswrite = 1'b0;
        @(posedge clk); @(negedge clk);
        check_eq("ack_pulse_end", {31'd0, ack}, 32'd0);
        @(posedge clk); @(negedge clk);
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [15:0] d);
        logic [15:0] dummy;
        bus(1'b1, a, d, 1'b0, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] r;
        bus(1'b0, a, 16'h0000, 1'b0, r);
        check_eq(tag, {16'd0, r}, {16'd0, exp});
    endtask

    initial begin
        logic [15:0] r;
        int n_ack;
        int errs;
        int highs;
        int first64;

        // Reset state, with a request pending during reset that must be dropped.
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ack",   {31'd0, ack},  32'd0);
        check_eq("rst_rdata", {16'd0, rdata}, 32'd0);
        check_eq("rst_leds",  {27'd0, leds}, 32'd0);
        check_eq("rst_sig1",  {31'd0, sig1}, 32'd0);
        check_eq("rst_sig2",  {31'd0, sig2}, 32'd0);
        valid = 1'b1; iswrite = 1'b1; addr = 16'h0001; wdata = 16'h001F;
        repeat (2) @(negedge clk);
        check_eq("rst_drop_ack",  {31'd0, ack},  32'd0);
        check_eq("rst_drop_leds", {27'd0, leds}, 32'd0);
        valid = 1'b0; iswrite = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        // ID and request counter (read returns pre-increment value).
        rd_chk("id", 16'h0000, 16'h4D53);
        rd_chk("reqs_1", 16'h0004, 16'h0001);

        // LEDS write with valid held long after ack: exactly one access.
        valid = 1'b1; iswrite = 1'b1; addr = 16'h0001; wdata = 16'hFFFF;
        n_ack = 0;
        repeat (12) begin
            @(negedge clk);
            if (ack) n_ack++;
        end
        valid = 1'b0; iswrite = 1'b0;
        @(negedge clk);
        check_eq("one_ack", n_ack, 32'd1);
        check_eq("leds_1f", {27'd0, leds}, 32'h1F);
        rd_chk("leds_rb", 16'h0001, 16'h001F);
        rd_chk("reqs_4", 16'h0004, 16'h0004);

        // DUTY readback, ID read-only, scratch and unmapped addresses.
        wr_reg(16'h0002, 16'h12AB);
        rd_chk("duty_rb", 16'h0002, 16'h00AB);
        wr_reg(16'h0000, 16'hFFFF);
        rd_chk("id_ro", 16'h0000, 16'h4D53);
        wr_reg(16'h0010, 16'hA5A5);
        wr_reg(16'h0013, 16'h1234);
        wr_reg(16'h0014, 16'hFFFF);
        wr_reg(16'h00FF, 16'hBEEF);
        rd_chk("scr0", 16'h0010, 16'hA5A5);
        rd_chk("scr3", 16'h0013, 16'h1234);
        rd_chk("scr1_rst", 16'h0011, 16'h0000);
        rd_chk("scr_beyond", 16'h0014, 16'h0000);
        rd_chk("unmapped", 16'h00FF, 16'h0000);
        rd_chk("leds_kept", 16'h0001, 16'h001F);

        // Frame error counter: count, coincident read, clear racing a pulse.
        repeat (3) begin
            frame_err = 1'b1; @(negedge clk);
            frame_err = 1'b0; @(negedge clk);
        end
        rd_chk("ferr_3", 16'h0003, 16'h0003);
        bus(1'b0, 16'h0003, 16'h0000, 1'b1, r);
        check_eq("ferr_rd_pre", {16'd0, r}, 32'd3);
        rd_chk("ferr_4", 16'h0003, 16'h0004);
        bus(1'b1, 16'h0003, 16'h5555, 1'b1, r);
        rd_chk("ferr_clr_pulse", 16'h0003, 16'h0001);
        wr_reg(16'h0003, 16'h0000);
        rd_chk("ferr_clr", 16'h0003, 16'h0000);

        // PWM: duty 64 written early in a period only takes effect at the wrap.
        wr_reg(16'h0002, 16'h0000);
        repeat (256) @(negedge clk);
        while ((edge_cnt % 256) != 20) @(negedge clk);
        wr_reg(16'h0002, 16'h0040);
        errs = 0;
        while ((edge_cnt % 256) != 0) begin
            if (sig1 !== 1'b0) errs++;
            @(negedge clk);
        end
        check_eq("pwm_prewrap_low", errs, 32'd0);
        highs = 0; first64 = 0;
        for (int i = 0; i < 256; i++) begin
            if (sig1 === 1'b1) begin
                highs++;
                if (i < 64) first64++;
            end
            @(negedge clk);
        end
        check_eq("pwm_highs", highs, 32'd64);
        check_eq("pwm_first64", first64, 32'd64);

        // Uptime: shadow untouched before any LO read, then LO at 70000 ms.
        while (edge_cnt < 69997) @(negedge clk);
        rd_chk("uphi_pre", 16'h0006, 16'h0000);
        rd_chk("uplo", 16'h0005, 16'h1170);
        rd_chk("uphi", 16'h0006, 16'h0001);
        check_eq("sig2", {31'd0, sig2}, (edge_cnt >> 9) & 1);

`ifdef MODSTICK_REGS_WDOG_EN
        // Watchdog: expires after 1000 idle ms, kept alive by periodic writes.
        wr_reg(16'h0001, 16'h0015);
        check_eq("wdog_set", {27'd0, leds}, 32'h15);
        repeat (1010) @(negedge clk);
        check_eq("wdog_expire", {27'd0, leds}, 32'h0);
        wr_reg(16'h0001, 16'h0015);
        for (int i = 0; i < 300; i++) begin
            wr_reg(16'h0010, 16'(i));
            @(negedge clk);
        end
        check_eq("wdog_kept", {27'd0, leds}, 32'h15);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
